// File: rtl/rv_pkg.sv
// Shared definitions for the memory / writeback stage.
// Holds writeback-select encodings, FSM state type and timeout width.
package rv_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam int TO_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic [31:0] wb_mux(
        input logic [1:0]  sel,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] pc4
    );
        logic [31:0] r;
        unique case (sel)
            WB_MEM:  r = mem;
            WB_PC4:  r = pc4;
            default: r = alu;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access timeout counter for the memory stage.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
    import rv_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic hit
);

    logic [TO_W-1:0] cnt;

    assign hit = run && (cnt == TO_W'(LIMIT - 1));

    // Count cycles spent waiting; restart whenever not waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and writeback stage with a two-state access FSM.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  wb_sel_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] writeback_data,
    output logic [4:0]  wb_rd_out,
    output logic        wb_reg_write_out,
    output logic        stall_out,
    output logic        mem_err_out
);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [4:0]  rd_q;
    logic [1:0]  sel_q;
    logic        we_q;
    logic        rw_q;
    logic        is_mem;
    logic        timeout_hit;

    assign is_mem     = mem_read_in | mem_write_in;
    assign dmem_req   = (state == ACCESS);
    assign stall_out  = (state == ACCESS);
    assign dmem_we    = (state == ACCESS) & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_to (
        .clk   (clk),
        .reset (reset),
        .run   (state == ACCESS),
        .hit   (timeout_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
`endif

    // Access FSM, operand latches and registered writeback outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            pc_q             <= '0;
            rd_q             <= '0;
            sel_q            <= '0;
            we_q             <= 1'b0;
            rw_q             <= 1'b0;
            writeback_data   <= '0;
            wb_rd_out        <= '0;
            wb_reg_write_out <= 1'b0;
            mem_err_out      <= 1'b0;
        end else begin
            wb_reg_write_out <= 1'b0;
            mem_err_out      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && is_mem) begin
                        if (alu_result_in[1:0] == 2'b00) begin
                            state   <= ACCESS;
                            addr_q  <= alu_result_in;
                            wdata_q <= rs2_data_in;
                            pc_q    <= pc_in;
                            rd_q    <= rd_in;
                            sel_q   <= wb_sel_in;
                            we_q    <= mem_write_in & ~mem_read_in;
                            rw_q    <= reg_write_in;
                        end else begin
                            mem_err_out <= 1'b1;
                        end
                    end else if (in_valid) begin
                        writeback_data   <= wb_mux(wb_sel_in, alu_result_in,
                                                   dmem_rdata, pc_in + 32'd4);
                        wb_rd_out        <= rd_in;
                        wb_reg_write_out <= reg_write_in && (rd_in != 5'd0);
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state <= IDLE;
                        if (!we_q) begin
                            writeback_data   <= wb_mux(sel_q, addr_q,
                                                       dmem_rdata, pc_q + 32'd4);
                            wb_rd_out        <= rd_q;
                            wb_reg_write_out <= rw_q && (rd_q != 5'd0);
                        end
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        mem_err_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a writeback scoreboard.
// Expected writebacks and error pulses are queued as stimulus is driven.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_data_in;
    logic [31:0] pc_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  wb_sel_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] writeback_data;
    logic [4:0]  wb_rd_out;
    logic        wb_reg_write_out;
    logic        stall_out;
    logic        mem_err_out;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  err_pend = 0;
    int  vectors  = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .alu_result_in    (alu_result_in),
        .rs2_data_in      (rs2_data_in),
        .pc_in            (pc_in),
        .rd_in            (rd_in),
        .reg_write_in     (reg_write_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .wb_sel_in        (wb_sel_in),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .writeback_data   (writeback_data),
        .wb_rd_out        (wb_rd_out),
        .wb_reg_write_out (wb_reg_write_out),
        .stall_out        (stall_out),
        .mem_err_out      (mem_err_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rw,
                         input logic rdm, input logic wrm,
                         input logic [1:0] sel);
        in_valid      = 1'b1;
        alu_result_in = alu;
        rs2_data_in   = rs2;
        rd_in         = rd;
        reg_write_in  = rw;
        mem_read_in   = rdm;
        mem_write_in  = wrm;
        wb_sel_in     = sel;
    endtask

    // Scoreboard: every write pulse and error pulse must be expected
    always @(negedge clk) begin
        if (!reset && wb_reg_write_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_data", writeback_data, e.data);
                chk("wb_rd", {27'd0, wb_rd_out}, {27'd0, e.rd});
            end
        end
        if (!reset && mem_err_out) begin
            if (err_pend == 0) begin
                chk("unexpected_err", 32'd1, 32'd0);
            end else begin
                err_pend--;
                vectors++;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        pc_in      = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        idle_in();
        step();
        step();
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_wbdata", writeback_data, 32'd0);
        chk("rst_wbwe", {31'd0, wb_reg_write_out}, 32'd0);
        chk("rst_err", {31'd0, mem_err_out}, 32'd0);
        reset = 1'b0;
        step();

        // ALU op rd=5
        drive(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00);
        exp_q.push_back('{rd: 5'd5, data: 32'h1234});
        step();
        idle_in();
        chk("alu_we", {31'd0, wb_reg_write_out}, 32'd1);
        chk("alu_rd", {27'd0, wb_rd_out}, 32'd5);
        chk("alu_data", writeback_data, 32'h1234);
        chk("alu_stall", {31'd0, stall_out}, 32'd0);
        step();
        chk("hold_we", {31'd0, wb_reg_write_out}, 32'd0);
        chk("hold_data", writeback_data, 32'h1234);
        chk("hold_rd", {27'd0, wb_rd_out}, 32'd5);

        // pc+4 and sel 11 paths
        pc_in = 32'h400;
        drive(32'h9999, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10);
        exp_q.push_back('{rd: 5'd3, data: 32'h404});
        step();
        drive(32'hCAFE, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b11);
        exp_q.push_back('{rd: 5'd4, data: 32'hCAFE});
        step();
        idle_in();

        // rd=0 must not write
        drive(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        idle_in();
        chk("rd0_we", {31'd0, wb_reg_write_out}, 32'd0);

        // ack while idle is ignored
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_stall", {31'd0, stall_out}, 32'd0);

        // load 0x100, ack on third access cycle
        drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", {31'd0, stall_out}, 32'd1);
            chk("ld_req", {31'd0, dmem_req}, 32'd1);
            chk("ld_addr", dmem_addr, 32'h100);
            chk("ld_we", {31'd0, dmem_we}, 32'd0);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
                exp_q.push_back('{rd: 5'd7, data: 32'hDEAD_BEEF});
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("ld_done_stall", {31'd0, stall_out}, 32'd0);
        chk("ld_done_req", {31'd0, dmem_req}, 32'd0);
        chk("ld_done_we", {31'd0, wb_reg_write_out}, 32'd1);

        // store 0x200, immediate ack
        drive(32'h200, 32'hA5A5_A5A5, 5'd2, 1'b0, 1'b0, 1'b1, 2'b00);
        step();
        idle_in();
        chk("st_req", {31'd0, dmem_req}, 32'd1);
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_addr", dmem_addr, 32'h200);
        chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_done_req", {31'd0, dmem_req}, 32'd0);
        chk("st_no_wb", {31'd0, wb_reg_write_out}, 32'd0);

        // read and write together behaves as a read
        drive(32'h300, 32'h7777, 5'd8, 1'b1, 1'b1, 1'b1, 2'b01);
        step();
        idle_in();
        chk("rw_we", {31'd0, dmem_we}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        exp_q.push_back('{rd: 5'd8, data: 32'h1111_2222});
        step();
        dmem_ack = 1'b0;

        // misaligned load
        drive(32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01);
        err_pend++;
        step();
        idle_in();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall_out}, 32'd0);
        chk("mis_err", {31'd0, mem_err_out}, 32'd1);
        chk("mis_we", {31'd0, wb_reg_write_out}, 32'd0);
        step();
        chk("mis_err_drop", {31'd0, mem_err_out}, 32'd0);

        // reset during access discards the transaction
        drive(32'h104, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01);
        step();
        idle_in();
        chk("ra_req", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ra_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("ra_stall_drop", {31'd0, stall_out}, 32'd0);
        chk("ra_addr", dmem_addr, 32'd0);
        step();
        reset = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        step();
        step();
        dmem_ack = 1'b0;
        chk("ra_no_req", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // no ack: error after 16 access cycles, late ack ignored
        drive(32'h108, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01);
        step();
        idle_in();
        chk("to_stall0", {31'd0, stall_out}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_stall", {31'd0, stall_out}, 32'd1);
        end
        err_pend++;
        step();
        chk("to_stall_drop", {31'd0, stall_out}, 32'd0);
        chk("to_err", {31'd0, mem_err_out}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("to_late_ack", {31'd0, wb_reg_write_out}, 32'd0);
`endif

        step();
        step();
        chk("wb_pending", exp_q.size(), 32'd0);
        chk("err_pending", err_pend, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 16, max ACCESS cycles awaiting dmem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL provide ports: clk  in  1  single clock; reset  in  1  asynchronous, active-high.
REQ-003 SHALL provide ports: in_valid  in  1  instruction presented from execute; alu_result_in  in  32  ALU result / address; rs2_data_in  in  32  store data; pc_in  in  32  instruction PC.
REQ-004 SHALL provide ports: rd_in  in  5  destination reg; reg_write_in, mem_read_in, mem_write_in  in  1 each  controls; wb_sel_in  in  2  00 ALU, 01 memory, 10 pc_in+4.
REQ-005 SHALL provide ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1.
REQ-006 SHALL provide ports: writeback_data  out  32; wb_rd_out  out  5; wb_reg_write_out  out  1 (register-file write port); stall_out  out  1; mem_err_out  out  1.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS; reset state IDLE.
REQ-008 IDLE, in_valid, no memory op: next edge drive writeback_data per wb_sel_in, wb_rd_out=rd_in, wb_reg_write_out=reg_write_in for exactly one cycle; latency 1.
REQ-009 wb_reg_write_out SHALL be forced 0 when rd=0; wb_sel 11 SHALL select ALU result.
REQ-010 IDLE, in_valid, mem_read_in or mem_write_in, alu_result_in[1:0]=00: next edge latch operands, enter ACCESS.
REQ-011 ACCESS: dmem_req=1, dmem_addr=latched address, dmem_we=latched write, dmem_wdata=latched rs2 data, all stable until ack.
REQ-012 Both mem_read_in and mem_write_in set: SHALL treat as read (dmem_we=0).
REQ-013 stall_out SHALL be 1 exactly while in ACCESS; in_valid ignored in ACCESS.
REQ-014 ACCESS with dmem_ack: on that edge capture dmem_rdata, go to IDLE, drop req; loads write back one-cycle pulse next cycle (data=dmem_rdata when wb_sel=01); stores produce no write.
REQ-015 Misaligned memory op (address[1:0]!=00): no dmem_req, no writeback, mem_err_out one-cycle pulse next edge, stay IDLE.
REQ-016 dmem_ack while IDLE SHALL be ignored.
REQ-017 Writeback outputs not pulsed SHALL hold last data/rd with wb_reg_write_out=0.

Reset
REQ-018 reset SHALL asynchronously force IDLE and every output to 0, including mid-ACCESS (dmem_req drops immediately, pending access discarded, no writeback).
REQ-019 Latched operands and counters SHALL clear to 0 on reset.

Configuration
REQ-020 Macro MEM_TIMEOUT_EN defined: counter increments each ACCESS cycle; after TIMEOUT_CYCLES cycles without ack, drop req, return IDLE, pulse mem_err_out one cycle, no writeback; ack on the same edge as timeout SHALL win.
REQ-021 MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; no counter logic; mem_err_out only from misalignment.

Structure
REQ-022 Shared package rv_pkg SHALL hold wb_sel encodings (WB_ALU, WB_MEM, WB_PC4), FSM state typedef, TIMEOUT width constant.
REQ-023 Sub-module mem_timeout_ctr SHALL implement the timeout counter, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-024 ALU op rd=5, alu_result=0x0000_1234, wb_sel=00 -> next cycle wb_reg_write_out=1, wb_rd_out=5, writeback_data=0x1234, stall_out=0.
REQ-025 Load addr 0x100, rd=7, ack after 3 cycles with rdata=0xDEADBEEF -> stall_out 1 for 3 cycles, req stable, then one-cycle write rd=7 data=0xDEADBEEF.
REQ-026 Store addr 0x200 data 0xA5A5A5A5, immediate ack -> dmem_we=1, wdata=0xA5A5A5A5, no register write.
REQ-027 Load addr 0x102 -> no dmem_req, mem_err_out pulse, no write; rd=0 ALU op -> wb_reg_write_out stays 0.
REQ-028 Reset asserted in ACCESS -> dmem_req, stall_out 0 same cycle, no later writeback; with MEM_TIMEOUT_EN, no ack -> mem_err_out after 16 ACCESS cycles, late ack ignored.
